// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and constants for the MLP weight loader.
//   wl_state_t        loader FSM states (IDLE, LOAD, DONE)
//   MLP_N / MLP_M     default neurons per layer / number of layers
//   MLP_WIDTH         default weight word width
//   WL_BEATS          words in one full weight set, M*N*(N+1)
//   WL_*_W            index widths derived with $clog2
package mlp_pkg;

   localparam int MLP_N     = 5;
   localparam int MLP_M     = 3;
   localparam int MLP_WIDTH = 8;

   localparam int WL_BEATS   = MLP_M * MLP_N * (MLP_N + 1);
   localparam int WL_LAYER_W = $clog2(MLP_M);
   localparam int WL_NEURON_W = $clog2(MLP_N);
   localparam int WL_IDX_W   = $clog2(MLP_N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } wl_state_t;

endpackage

// File: rtl/mlp_index_counter.sv
// mlp_index_counter: three-level wrapping address counter for the weight
// memory. k (word index, 0..N) is fastest, then j (neuron, 0..N-1), then
// i (layer, 0..M-1).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         zero all counters (takes priority over en)
//   en          advance by one word
//   i, j, k     current layer / neuron / word index
//   last        current position is the final word of the set
module mlp_index_counter
   import mlp_pkg::*;
#(
   parameter int N = MLP_N,
   parameter int M = MLP_M
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   output logic [$clog2(M)-1:0]     i,
   output logic [$clog2(N)-1:0]     j,
   output logic [$clog2(N+1)-1:0]   k,
   output logic                     last
);

   localparam int LW = $clog2(M);
   localparam int NW = $clog2(N);
   localparam int KW = $clog2(N + 1);

   localparam logic [LW-1:0] I_MAX = LW'(M - 1);
   localparam logic [NW-1:0] J_MAX = NW'(N - 1);
   localparam logic [KW-1:0] K_MAX = KW'(N);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (clr) begin
         i <= '0;
         j <= '0;
         k <= '0;
      end else if (en) begin
         if (k == K_MAX) begin
            k <= '0;
            if (j == J_MAX) begin
               j <= '0;
               // Wrap the layer too so the counter never leaves the legal range.
               i <= (i == I_MAX) ? '0 : i + 1'b1;
            end else begin
               j <= j + 1'b1;
            end
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   assign last = (i == I_MAX) && (j == J_MAX) && (k == K_MAX);

endmodule

// File: rtl/mlp_weight_loader.sv
// mlp_weight_loader: streams a full set of signed weights/biases from a
// valid/ready source into the n_neuron_mlp weight memory, address order
// layer, neuron, index (index fastest; index N is the bias).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_start                 pulse in IDLE to begin a weight set
//   w_valid/w_data/w_last      source stream; w_ready is high in LOAD
//   wr_en/wr_layer/wr_neuron/
//   wr_idx/wr_data             registered memory write, 1 cycle after accept
//   load_busy                  high while loading
//   load_done                  one-cycle pulse, coincides with final wr_en
//   load_err                   sticky w_last framing error
//   checksum[15:0]             only with WL_CHECKSUM_EN: running sum of
//                              sign-extended accepted words, mod 2^16
// Optional feature macro: WL_CHECKSUM_EN
module mlp_weight_loader
   import mlp_pkg::*;
#(
   parameter int N     = MLP_N,
   parameter int M     = MLP_M,
   parameter int WIDTH = MLP_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_start,
   input  logic                     w_valid,
   input  logic [WIDTH-1:0]         w_data,
   input  logic                     w_last,
   output logic                     w_ready,
   output logic                     wr_en,
   output logic [$clog2(M)-1:0]     wr_layer,
   output logic [$clog2(N)-1:0]     wr_neuron,
   output logic [$clog2(N+1)-1:0]   wr_idx,
   output logic [WIDTH-1:0]         wr_data,
   output logic                     load_busy,
   output logic                     load_done,
   output logic                     load_err
`ifdef WL_CHECKSUM_EN
   ,
   output logic [15:0]              checksum
`endif
);

   localparam int LW = $clog2(M);
   localparam int NW = $clog2(N);
   localparam int KW = $clog2(N + 1);

   wl_state_t state_reg, state_next;

   logic          handshake;
   logic          start_accept;
   logic          final_beat;
   logic [LW-1:0] cnt_i;
   logic [NW-1:0] cnt_j;
   logic [KW-1:0] cnt_k;

   mlp_index_counter #(
      .N (N),
      .M (M)
   ) u_index_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_accept),
      .en    (handshake),
      .i     (cnt_i),
      .j     (cnt_j),
      .k     (cnt_k),
      .last  (final_beat)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      w_ready    = 1'b0;
      load_busy  = 1'b0;
      load_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load_start) state_next = LOAD;
         end
         LOAD: begin
            w_ready   = 1'b1;
            load_busy = 1'b1;
            // Completion is decided by the beat count, never by w_last.
            if (w_valid && final_beat) state_next = DONE;
         end
         DONE: begin
            load_done  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign handshake    = w_valid && w_ready;
   assign start_accept = (state_reg == IDLE) && load_start;

   // ---------------- registered write port ----------------
   // Address/data hold their last value when no word is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en     <= 1'b0;
         wr_layer  <= '0;
         wr_neuron <= '0;
         wr_idx    <= '0;
         wr_data   <= '0;
      end else begin
         wr_en <= handshake;
         if (handshake) begin
            wr_layer  <= cnt_i;
            wr_neuron <= cnt_j;
            wr_idx    <= cnt_k;
            wr_data   <= w_data;
         end
      end
   end

   // ---------------- framing error ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_err <= 1'b0;
      end else if (start_accept) begin
         load_err <= 1'b0;
      end else if (handshake && (w_last != final_beat)) begin
         load_err <= 1'b1;
      end
   end

`ifdef WL_CHECKSUM_EN
   // ---------------- running checksum ----------------
   logic [15:0] data_ext;
   assign data_ext = {{(16-WIDTH){w_data[WIDTH-1]}}, w_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (start_accept) begin
         checksum <= '0;
      end else if (handshake) begin
         checksum <= checksum + data_ext;
      end
   end
`endif

endmodule

// File: doc/mlp_weight_loader.md
Name: mlp_weight_loader

Overview:
Streams weights and biases from a serial source into the n_neuron_mlp weights memory. It replaces hierarchical backdoor loading with a real write path.
- Accepts one signed word per valid/ready handshake.
- Walks the address space layer, then neuron, then index (index fastest).
- Issues registered memory writes and signals completion, so inference (soc) can start only after a full weight set is resident.

Parameters:
N, 5, inputs per neuron / neurons per layer
M, 3, number of layers
WIDTH, 8, weight word width (signed)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  one-cycle pulse: begin loading a full weight set
w_valid  input  1  stream word valid
w_data  input  WIDTH  signed weight/bias word
w_last  input  1  source marks final word of the set
w_ready  output  1  loader accepts a word this cycle
wr_en  output  1  memory write strobe
wr_layer  output  $clog2(M)  layer index i
wr_neuron  output  $clog2(N)  neuron index j
wr_idx  output  $clog2(N+1)  word index k (0..N-1 weights, N = bias)
wr_data  output  WIDTH  word to write
load_busy  output  1  high while in LOAD
load_done  output  1  one-cycle pulse after final write issued
load_err  output  1  sticky w_last framing error

Behaviour:
- Reset (async, rst_n=0): state IDLE; counters i, j, k = 0; all outputs 0; load_err cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - w_ready=0, load_busy=0.
  - load_start=1 -> LOAD, counters zeroed, load_err cleared.
- LOAD:
  - w_ready=1 (combinational from state), load_busy=1.
  - Handshake = w_valid && w_ready.
  - On handshake, next cycle: wr_en=1, wr_data=w_data, wr_layer/neuron/idx = counter values at handshake time. Write latency is exactly 1 cycle.
  - No handshake -> wr_en=0 next cycle; address/data outputs hold.
  - Counter advance: k increments; at k=N it wraps to 0 and j increments; at j=N-1 it wraps to 0 and i increments.
  - Final beat (i=M-1, j=N-1, k=N) -> DONE. Total beats = M*N*(N+1) (90 at defaults).
  - Framing: w_last=1 on a non-final beat, or w_last=0 on the final beat -> load_err=1 (sticky). Loading continues by count, not by w_last.
  - load_start during LOAD is ignored.
  - w_valid gaps of any length are allowed; counters freeze.
- DONE:
  - w_ready=0; wr_en shows the final write this cycle.
  - load_done=1 for exactly this cycle, then -> IDLE.
  - Final write is on wr_en in the same cycle as load_done.
- load_start in DONE is ignored; a new load requires a pulse in IDLE.
- Reset mid-LOAD: immediate return to IDLE. A partial set stays in memory, and no load_done is issued.
- w_data passes through unmodified; no sign extension or saturation.

Optional Feature:
- Macro WL_CHECKSUM_EN.
  - Defined: adds output checksum[15:0], the running sum of w_data (sign-extended to 16 bits, mod 2^16) over accepted beats. It is cleared on load_start accepted in IDLE and on reset, and is valid and stable from load_done onward.
  - Undefined: no checksum port and no accumulator logic; all other behaviour is identical.

Decomposition:
- Shared package mlp_pkg:
  - typedef enum {IDLE, LOAD, DONE} wl_state_t
  - localparam WL_BEATS = M*N*(N+1)
  - index width localparams derived with $clog2
- One sub-module is natural: mlp_index_counter, the 3-level wrapping i/j/k counter with enable, clear, and a last flag.

Test Plan:
- Reset then load_start, 90 contiguous beats w_data=0..89, w_last on beat 89:
  - beat 0 writes (0,0,0)=0; beat 6 writes (0,1,0)=6; beat 89 writes (2,4,5)=89
  - load_done pulses once, in the same cycle as the final wr_en
  - load_err=0
- Random w_valid gaps (30% idle), beats 0..89: identical write sequence; wr_en count = 90; no duplicate or missed addresses.
- w_last asserted on beat 10:
  - load_err=1 after beat 10 and stays 1
  - load still completes at beat 89 with load_done
- Assert rst_n=0 after beat 40:
  - all outputs 0, state IDLE, no load_done
  - new load_start performs a full fresh 90-beat load from (0,0,0)
- load_start pulses during LOAD at beat 20 and in the DONE cycle: no counter restart, no effect.
- With WL_CHECKSUM_EN, all 90 beats w_data=-1 (8'hFF): checksum = 16'hFFA6 at load_done.
